// File: rtl/axis_sync_fifo_if.sv
// rtl/axis_sync_fifo_if.sv - AXI-Stream beat bundle for the synchronous packet FIFO
// The master drives data/valid/last and the slave drives ready.
interface axis_sync_fifo_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - show-ahead synchronous AXI-Stream FIFO with beat and packet occupancy
// tlast is stored alongside each beat, so packet boundaries travel with their data.
module axis_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  axis_sync_fifo_if.slave         s_axis,
  axis_sync_fifo_if.master        m_axis,
  output logic [CW-1:0]           o_count,
  output logic [CW-1:0]           o_pkt_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW:0]    r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  r_pkt_count;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_pkt_inc;
  logic           w_pkt_dec;
  logic [DW:0]    w_head;

  // Flags come only from registered occupancy, so a pop frees space one cycle later.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign s_axis.tready = !w_full && !i_rst;
  assign m_axis.tvalid = !w_empty;

  assign w_head        = r_mem[r_rd_ptr];
  assign m_axis.tdata  = w_head[DW-1:0];
  assign m_axis.tlast  = w_head[DW];

  assign w_push    = s_axis.tvalid && s_axis.tready;
  assign w_pop     = m_axis.tvalid && m_axis.tready && !i_rst;
  assign w_pkt_inc = w_push && s_axis.tlast;
  assign w_pkt_dec = w_pop && w_head[DW];

  assign o_count     = r_count;
  assign o_pkt_count = r_pkt_count;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis.tlast, s_axis.tdata};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pkt_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_pkt_count <= r_pkt_count + CW'(w_pkt_inc) - CW'(w_pkt_dec);
    end
  end
endmodule

// File: tb/tb_axis_sync_fifo.sv
// tb/tb_axis_sync_fifo.sv - scoreboard bench for axis_sync_fifo against a queue reference
// Inputs change 1ns after posedge; monitors sample on negedge.
module tb_axis_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [CW-1:0] count;
  logic [CW-1:0] pkt_count;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  logic [DW:0] exp_q [$];

  axis_sync_fifo_if #(.DW(DW)) s_if ();
  axis_sync_fifo_if #(.DW(DW)) m_if ();

  axis_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .o_count     (count),
    .o_pkt_count (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Output monitor: occupancy/flag checks against the model, then pop and compare.
  always @(negedge clk) begin : out_mon
    int pk;
    logic [DW:0] e;
    pk = 0;
    foreach (exp_q[i]) pk += int'(exp_q[i][DW]);
    check("count", 32'(count), 32'(exp_q.size()));
    check("pkt_count", 32'(pkt_count), 32'(pk));
    check("m_tvalid", 32'(m_if.tvalid), 32'(exp_q.size() != 0));
    check("s_tready", 32'(s_if.tready), 32'(!rst && exp_q.size() != DEPTH));
    if (rst) begin
      exp_q.delete();
    end else if (m_if.tvalid && m_if.tready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("m_tdata", 32'(m_if.tdata), 32'(e[DW-1:0]));
      check("m_tlast", 32'(m_if.tlast), 32'(e[DW]));
      pops++;
    end
  end

  // Input monitor: record every accepted beat after the output monitor has run.
  always @(negedge clk) begin
    #1;
    if (!rst && s_if.tvalid && s_if.tready) begin
      exp_q.push_back({s_if.tlast, s_if.tdata});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    while (!s_if.tready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("push_timeout", 32'(n), 32'(0));
    step();
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (count != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check("drain_timeout", 32'(n), 32'(0));
    step();
  endtask

  initial begin
    int p0;
    rst         = 1'b1;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_count", 32'(count), 32'(0));
    check("rst_tready", 32'(s_if.tready), 32'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 32'(s_if.tready), 32'(1));
    step();

    // Three-beat packet held, then drained in order.
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    @(negedge clk);
    check("pkt3_count", 32'(count), 32'(3));
    check("pkt3_pkt", 32'(pkt_count), 32'(1));
    step();
    m_if.tready = 1'b1;
    wait_empty();
    m_if.tready = 1'b0;

    // Fill to full; a 17th beat is held back, then full push+pop.
    for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i), (i % 4) == 3);
    s_if.tdata  = 8'hAA;
    s_if.tlast  = 1'b1;
    s_if.tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("full_count", 32'(count), 32'(DEPTH));
      check("full_tready", 32'(s_if.tready), 32'(0));
      step();
    end
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    @(negedge clk);
    check("after_full_pop_count", 32'(count), 32'(DEPTH - 1));
    check("after_full_pop_tready", 32'(s_if.tready), 32'(1));
    step();
    s_if.tvalid = 1'b0;
    @(negedge clk);
    check("held_beat_in", 32'(count), 32'(DEPTH));
    step();
    m_if.tready = 1'b1;
    wait_empty();

    // Streaming at one beat per cycle through several pointer wraps.
    p0 = pops;
    for (int i = 0; i < 40; i++) begin
      s_if.tdata  = 8'(i);
      s_if.tlast  = (i % 8) == 7;
      s_if.tvalid = 1'b1;
      @(negedge clk);
      if (i > 0) check("stream_count", 32'(count), 32'(1));
      step();
    end
    s_if.tvalid = 1'b0;
    wait_empty();
    check("stream_pops", 32'(pops - p0), 32'(40));
    m_if.tready = 1'b0;

    // Reset with stored beats discards everything.
    for (int i = 0; i < 5; i++) push(8'(8'h80 + i), (i == 1) || (i == 4));
    @(negedge clk);
    check("pre_rst_count", 32'(count), 32'(5));
    check("pre_rst_pkt", 32'(pkt_count), 32'(2));
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("mid_rst_count", 32'(count), 32'(0));
    check("mid_rst_pkt", 32'(pkt_count), 32'(0));
    check("mid_rst_tvalid", 32'(m_if.tvalid), 32'(0));
    check("mid_rst_tready", 32'(s_if.tready), 32'(0));
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rel_rst_tready", 32'(s_if.tready), 32'(1));
    check("rel_rst_count", 32'(count), 32'(0));
    step();

    // Random traffic on both sides.
    for (int c = 0; c < 10000; c++) begin
      s_if.tvalid = ($urandom_range(0, 99) < 60);
      s_if.tdata  = 8'($urandom);
      s_if.tlast  = ($urandom_range(0, 3) == 0);
      m_if.tready = ($urandom_range(0, 99) < 55);
      step();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    wait_empty();
    check("final_model_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_sync_fifo.md
AXIS_SYNC_FIFO -- requirements
Module: axis_sync_fifo

Interface
REQ-001 Parameter DW, default 8, tdata width in bits; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of 2 and at least 2.
REQ-003 Parameter CW, default $clog2(DEPTH)+1, width of the occupancy and packet counters.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 s_tdata  input  DW  upstream beat data.
REQ-007 s_tvalid  input  1  upstream beat valid.
REQ-008 s_tlast  input  1  upstream end-of-packet marker.
REQ-009 s_tready  output  1  FIFO can accept a beat.
REQ-010 m_tdata  output  DW  head-of-FIFO data.
REQ-011 m_tvalid  output  1  head entry present.
REQ-012 m_tlast  output  1  tlast of the head entry.
REQ-013 m_tready  input  1  downstream accepts a beat.
REQ-014 count  output  CW  number of stored beats, 0..DEPTH.
REQ-015 pkt_count  output  CW  number of stored beats with tlast=1.

Function
REQ-016 Push occurs in a cycle where s_tvalid=1 and s_tready=1; the beat (tdata, tlast) SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-017 Pop occurs in a cycle where m_tvalid=1 and m_tready=1; rd_ptr SHALL increment modulo DEPTH.
REQ-018 Show-ahead: m_tdata and m_tlast SHALL present the entry at rd_ptr whenever m_tvalid=1, with no read-request cycle.
REQ-019 Latency: a beat pushed in cycle N into an empty FIFO SHALL appear with m_tvalid=1 in cycle N+1; there SHALL be no combinational path from s_* to m_*.
REQ-020 m_tvalid SHALL be 1 exactly when count != 0; s_tready SHALL be 1 exactly when count != DEPTH and rst=0.
REQ-021 s_tready SHALL NOT depend combinationally on m_tready; a pop does not free space until the next cycle.
REQ-022 count SHALL increment on push only, decrement on pop only, and hold on simultaneous push and pop.
REQ-023 pkt_count SHALL increment on a push with s_tlast=1 and decrement on a pop with m_tlast=1; the net change SHALL be applied when both occur in the same cycle.
REQ-024 Full (count=DEPTH): s_tready=0 and no write; a pop in the same cycle SHALL still complete.
REQ-025 Empty (count=0): m_tvalid=0 and no pop regardless of m_tready; a push in the same cycle SHALL still complete.
REQ-026 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order SHALL be strictly preserved.
REQ-027 The FIFO SHALL NOT drop, duplicate or reorder beats; tlast SHALL travel with its data.
REQ-028 m_tdata and m_tlast are don't-care while m_tvalid=0.

Reset
REQ-029 While rst=1: wr_ptr=0, rd_ptr=0, count=0, pkt_count=0, m_tvalid=0, s_tready=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored beats within the same edge; any push or pop in that cycle SHALL be ignored.
REQ-031 In the first cycle after rst deasserts, s_tready SHALL be 1.
REQ-032 Storage memory needs no reset.

Verification
REQ-033 Scenario: push 3 beats 0x11, 0x22, 0x33 (tlast on 0x33) with m_tready=0 -> count=3, pkt_count=1; then m_tready=1 -> outputs 0x11, 0x22, 0x33 in order, tlast only on 0x33, count returns to 0.
REQ-034 Scenario: fill DEPTH=16 beats with m_tready=0 -> s_tready=0 after the 16th push, count=16; a 17th beat is held by upstream and not lost.
REQ-035 Scenario: FIFO full, then push and pop in the same cycle -> the pop completes, the push does not; next cycle count=15 and s_tready=1.
REQ-036 Scenario: continuous push and pop with both valid and ready held 1 for 40 beats (incrementing data) -> after the first beat, throughput is 1 beat/cycle; count stays at 1; pointers wrap at least twice with correct order.
REQ-037 Scenario: 5 beats stored with pkt_count=2, then rst pulsed for 1 cycle -> during reset count=0, pkt_count=0, m_tvalid=0, s_tready=0; next cycle s_tready=1 and the FIFO is empty.
REQ-038 Scenario: random valid/ready on both sides for 10k cycles against a reference queue model -> zero mismatches, and count and pkt_count always equal the model's values.
